sram_async_port_master: RTL and testbench

- Synchronous initiator for one async side of the 4-port SRAM multiplexer. Drives that side's ADDR/DATA/WE_N/OE_N and receives its returned data.
- Converts a single-word request/ready handshake into a timed SRAM strobe sequence, with programmable setup, pulse and hold phases.
- Honours a grant input, which is high when the multiplexer select points at this port. Restarts any access cut off by a grant loss.
- Sits between a client engine (e.g. USB/DMA or video logic) and one AS1/AS2/AS3 port of the multiplexer.

---
 rtl/sram_async_port_master.sv | 162 ++++++++++++++++
 tb/tb_sram_async_port_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_async_port_master.sv
// Synchronous initiator for one async port of the 4-port SRAM multiplexer.
// Turns a single-word req/ready handshake into a setup/pulse/hold strobe sequence gated by iGRANT.
module sram_async_port_master #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iREQ,
    input  logic        iWR,
    input  logic [17:0] iADDR,
    input  logic [15:0] iWDATA,
    output logic        oREADY,
    output logic        oDONE,
    output logic [15:0] oRDATA,
    output logic        oRETRY,
    input  logic        iGRANT,
    output logic [17:0] oAS_ADDR,
    output logic [15:0] oAS_DATA,
    output logic        oAS_WE_N,
    output logic        oAS_OE_N,
    input  logic [15:0] iAS_DATA
);

    localparam int unsigned SetupN = (SETUP_CYC == 0) ? 1 : SETUP_CYC;
    localparam int unsigned PulseN = (PULSE_CYC == 0) ? 1 : PULSE_CYC;
    localparam int unsigned HoldN  = (HOLD_CYC == 0) ? 1 : HOLD_CYC;

    localparam logic [3:0] SetupLast = 4'(SetupN - 1);
    localparam logic [3:0] PulseLast = 4'(PulseN - 1);
    localparam logic [3:0] HoldLast  = 4'(HoldN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StSetup,
        StAccess,
        StHold
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_wr, w_wr_nxt;
    logic [17:0] r_addr, w_addr_nxt;
    logic [15:0] r_data, w_data_nxt;
    logic [15:0] r_rdata, w_rdata_nxt;
    logic        r_we_n, w_we_n_nxt;
    logic        r_oe_n, w_oe_n_nxt;
    logic        r_done, w_done_nxt;
    logic        r_retry, w_retry_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_nxt    = r_wr;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_rdata_nxt = r_rdata;
        w_done_nxt  = 1'b0;
        w_retry_nxt = 1'b0;

        case (r_state)
            StIdle: begin
                if (iREQ) begin
                    w_wr_nxt    = iWR;
                    w_addr_nxt  = iADDR;
                    w_data_nxt  = iWDATA;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = iGRANT ? StSetup : StWait;
                end
            end
            StWait: begin
                if (iGRANT) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = StSetup;
                end
            end
            StSetup: begin
                if (!iGRANT) begin
                    w_cnt_nxt   = 4'd0;
                    w_retry_nxt = 1'b1;
                    w_state_nxt = StWait;
                end else if (r_cnt == SetupLast) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = StAccess;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            StAccess: begin
                // A cut-off strobe restarts from SETUP once the grant returns
                if (!iGRANT) begin
                    w_cnt_nxt   = 4'd0;
                    w_retry_nxt = 1'b1;
                    w_state_nxt = StWait;
                end else if (r_cnt == PulseLast) begin
                    if (!r_wr) begin
                        w_rdata_nxt = iAS_DATA;
                    end
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = StHold;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            StHold: begin
                if (r_cnt == HoldLast) begin
                    w_cnt_nxt   = 4'd0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = StIdle;
            end
        endcase

        // Strobes are registered, so they are decoded from the state being entered
        w_we_n_nxt = !((w_state_nxt == StAccess) && w_wr_nxt);
        w_oe_n_nxt = !(((w_state_nxt == StSetup) || (w_state_nxt == StAccess)) && !w_wr_nxt);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_addr  <= 18'd0;
            r_data  <= 16'd0;
            r_rdata <= 16'd0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_done  <= 1'b0;
            r_retry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wr    <= w_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_rdata <= w_rdata_nxt;
            r_we_n  <= w_we_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_done  <= w_done_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    assign oREADY   = (r_state == StIdle);
    assign oDONE    = r_done;
    assign oRDATA   = r_rdata;
    assign oRETRY   = r_retry;
    assign oAS_ADDR = r_addr;
    assign oAS_DATA = r_data;
    assign oAS_WE_N = r_we_n;
    assign oAS_OE_N = r_oe_n;

endmodule

// File: tb/tb_sram_async_port_master.sv
// Bench for sram_async_port_master: vector table per access, read-data scoreboard,
// plus hand sequences for back-to-back with custom phases and reset mid-access.
module tb_sram_async_port_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_req, a_wr, a_grant, a_ready, a_done, a_retry, a_we_n, a_oe_n;
    logic [17:0] a_addr, a_as_addr;
    logic [15:0] a_wdata, a_rdata, a_as_data, a_as_rdata;

    logic        b_req, b_wr, b_grant, b_ready, b_done, b_retry, b_we_n, b_oe_n;
    logic [17:0] b_addr, b_as_addr;
    logic [15:0] b_wdata, b_rdata, b_as_data;

    sram_async_port_master u_dut_a (
        .iCLK     (clk),
        .iRST_n   (rst_n),
        .iREQ     (a_req),
        .iWR      (a_wr),
        .iADDR    (a_addr),
        .iWDATA   (a_wdata),
        .oREADY   (a_ready),
        .oDONE    (a_done),
        .oRDATA   (a_rdata),
        .oRETRY   (a_retry),
        .iGRANT   (a_grant),
        .oAS_ADDR (a_as_addr),
        .oAS_DATA (a_as_data),
        .oAS_WE_N (a_we_n),
        .oAS_OE_N (a_oe_n),
        .iAS_DATA (a_as_rdata)
    );

    sram_async_port_master #(
        .SETUP_CYC (2),
        .PULSE_CYC (3),
        .HOLD_CYC  (2)
    ) u_dut_b (
        .iCLK     (clk),
        .iRST_n   (rst_n),
        .iREQ     (b_req),
        .iWR      (b_wr),
        .iADDR    (b_addr),
        .iWDATA   (b_wdata),
        .oREADY   (b_ready),
        .oDONE    (b_done),
        .oRDATA   (b_rdata),
        .oRETRY   (b_retry),
        .iGRANT   (b_grant),
        .oAS_ADDR (b_as_addr),
        .oAS_DATA (b_as_data),
        .oAS_WE_N (b_we_n),
        .oAS_OE_N (b_oe_n),
        .iAS_DATA (16'h0000)
    );

    // Small SRAM behind port A; reloaded with a known pattern while reset is low
    logic [15:0] sram [0:255];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) sram[i] <= 16'(i) ^ 16'hC300;
            sram[255] <= 16'h1234;
        end else if (!a_we_n) begin
            sram[a_as_addr[7:0]] <= a_as_data;
        end
    end
    assign a_as_rdata = a_oe_n ? 16'h0000 : sram[a_as_addr[7:0]];

    logic [15:0] model [0:255];

    typedef struct packed {
        logic        wr;
        logic [17:0] addr;
        logic [15:0] rdata;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        wr;
        logic [17:0] addr;
        logic [15:0] wdata;
        int          gstart;
        int          glen;
        logic [31:0] we_m;
        logic [31:0] oe_m;
        logic [31:0] done_m;
        logic [31:0] retry_m;
        int          rdk;
    } vec_t;

    localparam int NVec = 10;
    localparam int NCyc = 12;
    vec_t vecs [NVec];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard pop on oDONE, plus the strobe-exclusivity invariant
    initial begin
        sb_t e;
        int  depth;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("strobe_overlap", 32'(!a_we_n && !a_oe_n), 32'd0);
                if (a_done) begin
                    depth = sbq.size();
                    chk("sb_pending_at_done", 32'(depth > 0), 32'd1);
                    if (depth > 0) begin
                        e = sbq.pop_front();
                        if (!e.wr) chk("sb_rdata", 32'(a_rdata), 32'(e.rdata));
                    end
                end
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] we_m, oe_m, done_m, retry_m;
        bit          addr_ok, seen_done;
        sb_t         e;
        we_m = '0; oe_m = '0; done_m = '0; retry_m = '0;
        addr_ok = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < NCyc; k++) begin
            @(posedge clk);
            #1;
            we_m[k]    = !a_we_n;
            oe_m[k]    = !a_oe_n;
            done_m[k]  = a_done;
            retry_m[k] = a_retry;
            if (k == 0) begin
                chk($sformatf("v%0d_ready_at_accept", idx), 32'(a_ready), 32'd1);
                a_req   = 1'b1;
                a_wr    = v.wr;
                a_addr  = v.addr;
                a_wdata = v.wdata;
                e.wr    = v.wr;
                e.addr  = v.addr;
                e.rdata = model[v.addr[7:0]];
                sbq.push_back(e);
                if (v.wr) model[v.addr[7:0]] = v.wdata;
            end else begin
                a_req = 1'b0;
                if (!seen_done && ((a_as_addr != v.addr) || (v.wr && (a_as_data != v.wdata))))
                    addr_ok = 1'b0;
            end
            if (k == v.rdk && k != 0)
                chk($sformatf("v%0d_rdata_early", idx), 32'(a_rdata), 32'(e.rdata));
            if (a_done) seen_done = 1'b1;
            a_grant = !((k >= v.gstart) && (k < v.gstart + v.glen));
        end
        a_grant = 1'b1;
        chk($sformatf("v%0d_we_mask", idx), we_m, v.we_m);
        chk($sformatf("v%0d_oe_mask", idx), oe_m, v.oe_m);
        chk($sformatf("v%0d_done_mask", idx), done_m, v.done_m);
        chk($sformatf("v%0d_retry_mask", idx), retry_m, v.retry_m);
        chk($sformatf("v%0d_addr_data_stable", idx), 32'(addr_ok), 32'd1);
    endtask

    initial begin
        logic [31:0] we_m, oe_m, done_m, ready_m;
        int          n_done;

        for (int i = 0; i < 256; i++) model[i] = 16'(i) ^ 16'hC300;
        model[255] = 16'h1234;

        // wr addr wdata gstart glen we_m oe_m done_m retry_m rdk
        vecs[0] = '{1'b1, 18'h00155, 16'hA5C3, 99, 0, 32'h000C, 32'h0000, 32'h0020, 32'h0000, 0};
        vecs[1] = '{1'b0, 18'h3FFFF, 16'h0000, 99, 0, 32'h0000, 32'h000E, 32'h0020, 32'h0000, 4};
        vecs[2] = '{1'b0, 18'h00155, 16'hFFFF, 99, 0, 32'h0000, 32'h000E, 32'h0020, 32'h0000, 4};
        vecs[3] = '{1'b1, 18'h000A0, 16'h5A5A, 0,  4, 32'h00C0, 32'h0000, 32'h0200, 32'h0000, 0};
        vecs[4] = '{1'b0, 18'h000A0, 16'h0000, 0,  4, 32'h0000, 32'h00E0, 32'h0200, 32'h0000, 8};
        vecs[5] = '{1'b1, 18'h00155, 16'h0F0F, 2,  1, 32'h0064, 32'h0000, 32'h0100, 32'h0008, 0};
        vecs[6] = '{1'b0, 18'h00155, 16'h0000, 1,  1, 32'h0000, 32'h003A, 32'h0080, 32'h0004, 6};
        vecs[7] = '{1'b0, 18'h000A0, 16'h0000, 3,  1, 32'h0000, 32'h00EE, 32'h0200, 32'h0010, 8};
        vecs[8] = '{1'b1, 18'h00033, 16'hBEEF, 4,  1, 32'h000C, 32'h0000, 32'h0020, 32'h0000, 0};
        vecs[9] = '{1'b0, 18'h00033, 16'h0000, 99, 0, 32'h0000, 32'h000E, 32'h0020, 32'h0000, 4};

        rst_n = 1'b0;
        a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_grant = 1'b1;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_a", {a_we_n, a_oe_n, a_as_addr, a_as_data, a_rdata, a_done, a_retry, a_ready},
            {1'b1, 1'b1, 18'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1});
        chk("reset_state_b", {b_we_n, b_oe_n, b_as_addr, b_done, b_retry, b_ready},
            {1'b1, 1'b1, 18'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVec; i++) run_vec(i, vecs[i]);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Back-to-back writes on the 2/3/2 instance; second accept lands in the first done cycle
        we_m = '0; oe_m = '0; done_m = '0; ready_m = '0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            we_m[k]    = !b_we_n;
            oe_m[k]    = !b_oe_n;
            done_m[k]  = b_done;
            ready_m[k] = b_ready;
            if (k == 8) chk("b2b_addr_first_held", 32'(b_as_addr), 32'h00011);
            if (k == 9) chk("b2b_addr_second", 32'(b_as_addr), 32'h00022);
            if (k == 0) begin
                b_req = 1'b1; b_wr = 1'b1; b_addr = 18'h00011; b_wdata = 16'h1111;
            end else if (k == 1) begin
                b_addr = 18'h00022; b_wdata = 16'h2222;
            end else if (k == 9) begin
                b_req = 1'b0;
            end
        end
        chk("b2b_we_mask", we_m, 32'h0000_3838);
        chk("b2b_oe_mask", oe_m, 32'h0000_0000);
        chk("b2b_done_mask", done_m, 32'h0001_0100);
        chk("b2b_ready_mask", ready_m, 32'h000F_0101);

        // Reset asserted during the ACCESS phase of a write
        @(posedge clk);
        #1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 18'h00077; a_wdata = 16'h7777; a_grant = 1'b1;
        @(posedge clk);
        #1;
        a_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_we_low_before", 32'(a_we_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_async_outputs", {a_we_n, a_oe_n, a_as_addr, a_as_data},
            {1'b1, 1'b1, 18'd0, 16'd0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_ready_after", 32'(a_ready), 32'd1);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (a_done) n_done++;
            @(posedge clk);
            #1;
        end
        chk("rst_mid_no_done", 32'(n_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
